// File: rtl/sobel_ctrl_pkg.sv
// Shared types and constants for the sobel frame controller.
// Build option SOBEL_CTRL_STATS_EN adds frame/stall statistics.
package sobel_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } ctrl_state_t;

   typedef logic [23:0] rgb_t;

   localparam int IMG_W     = 1920;
   localparam int IMG_H     = 1080;
   localparam int FRAME_PIX = IMG_W * IMG_H;

   function automatic int frame_pix(input int w, input int h);
      return w * h;
   endfunction

endpackage

// File: rtl/sobel_xy_cnt.sv
// Raster x/y position counter with start-of-frame and end-of-line flags.
module sobel_xy_cnt #(
   parameter int W  = 1920,
   parameter int H  = 1080,
   parameter int XW = $clog2(W + 1),
   parameter int YW = $clog2(H + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic adv,
   output logic sof,
   output logic eol,
   output logic last
);

   logic [XW-1:0] x;
   logic [YW-1:0] y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (clr) begin
         x <= '0;
         y <= '0;
      end else if (adv) begin
         if (x == XW'(W - 1)) begin
            x <= '0;
            y <= (y == YW'(H - 1)) ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

   assign sof  = (x == '0) && (y == '0);
   assign eol  = (x == XW'(W - 1));
   assign last = eol && (y == YW'(H - 1));

endmodule

// File: rtl/sobel_frame_ctrl.sv
// One-frame-per-start sequencer in front of sobel_top.
// Optional outputs frame_cnt/stall_cnt under SOBEL_CTRL_STATS_EN.
module sobel_frame_ctrl
   import sobel_ctrl_pkg::*;
#(
   parameter int IMG_W   = 1920,
   parameter int IMG_H   = 1080,
   parameter int CNT_W   = 22,
   parameter int TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [8:0]  cfg_threshold,
   input  logic        cfg_sobel_en,
   input  logic [23:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [23:0] m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_sof,
   output logic        m_eol,
   output logic [8:0]  threshold,
   output logic        sobel_en,
   input  logic        o_valid,
   input  logic        o_ready,
`ifdef SOBEL_CTRL_STATS_EN
   output logic [15:0] frame_cnt,
   output logic [31:0] stall_cnt,
`endif
   output logic        busy,
   output logic        frame_done,
   output logic        frame_err
);

   localparam int NPIX = frame_pix(IMG_W, IMG_H);
   localparam int TW   = $clog2(TIMEOUT + 1);

   ctrl_state_t      state;
   logic [CNT_W-1:0] out_cnt;
   logic [TW-1:0]    timer;
   logic             run, active, arm;
   logic             in_fire, out_fire;
   logic             last_pix, cnt_full, cnt_fin;
   rgb_t             pix;

   assign run      = (state == RUN);
   assign active   = (state == RUN) || (state == DRAIN);
   assign arm      = (state == IDLE) && start;
   assign pix      = s_data;
   assign m_data   = pix;
   assign m_valid  = s_valid & run;
   assign s_ready  = m_ready & run;
   assign in_fire  = s_valid & s_ready;
   assign out_fire = o_valid & o_ready;
   assign cnt_full = (out_cnt == CNT_W'(NPIX));
   assign cnt_fin  = cnt_full ||
                     (out_fire && out_cnt == CNT_W'(NPIX - 1));

   sobel_xy_cnt #(
      .W (IMG_W),
      .H (IMG_H)
   ) u_xy (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (arm),
      .adv   (in_fire),
      .sof   (m_sof),
      .eol   (m_eol),
      .last  (last_pix)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         out_cnt    <= '0;
         timer      <= '0;
         threshold  <= '0;
         sobel_en   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         // beats past a full frame are an overrun and never counted
         if (active && out_fire) begin
            if (cnt_full) frame_err <= 1'b1;
            else out_cnt <= out_cnt + 1'b1;
         end
         unique case (state)
            IDLE: if (start) begin
               state     <= RUN;
               busy      <= 1'b1;
               threshold <= cfg_threshold;
               sobel_en  <= cfg_sobel_en;
               out_cnt   <= '0;
               timer     <= '0;
               frame_err <= 1'b0;
            end
            RUN: if (in_fire && last_pix) begin
               state <= DRAIN;
               timer <= '0;
            end
            DRAIN: begin
               if (cnt_fin) begin
                  state      <= DONE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
               end else if (out_fire) begin
                  timer <= '0;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  state      <= DONE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  frame_err  <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            DONE: state <= IDLE;
         endcase
      end
   end

`ifdef SOBEL_CTRL_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (frame_done) frame_cnt <= frame_cnt + 1'b1;
         if (arm) stall_cnt <= '0;
         else if (run && s_valid && !m_ready && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule
